// File: rtl/fifo_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_pkg
//   Shared types for the FIFO stream reader.
//   stage_state_e : occupancy state of the two-entry output stage. The numeric
//                   encoding equals the number of held entries, so it is
//                   driven straight out as occupancy_o.
// -----------------------------------------------------------------------------
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/fifo_stream_reader_stage.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_stage
//   Two-entry output stage (main + skid register) with its state machine.
//   The main register is always the stream head; the skid register catches a
//   word popped in the same cycle the consumer stalled.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (state and data to 0)
//   flush_i      discard both entries (data registers keep their contents)
//   load_i       a word is popped from the FIFO this cycle
//   load_data_i  the popped word
//   accept_i     the current head is taken by the consumer this cycle
//   state_o      stage state, encoded as occupancy (0..2)
//   data_o       main register (stream head)
// -----------------------------------------------------------------------------
module fifo_stream_reader_stage
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  accept_i,
    output logic [1:0]            state_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    stage_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load_i) begin
                        state_d = HALF;
                        main_d  = load_data_i;
                    end
                end
                HALF: begin
                    if (load_i && accept_i) begin
                        main_d = load_data_i;
                    end else if (load_i) begin
                        state_d = FULL;
                        skid_d  = load_data_i;
                    end else if (accept_i) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Pop is blocked while full, so only the skid moves up.
                    if (accept_i) begin
                        state_d = HALF;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign state_o = state_q;
    assign data_o  = main_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a FIFO pop interface into a registered valid/ready stream through a
//   two-entry output stage. The pop strobe depends only on the FIFO empty flag,
//   the stage state, flush and reset -- never on ready_i.
//
// Optional build macro: FIFO_STREAM_READER_STATS_EN
//   defined   : beat_cnt_o counts accepted beats (wraps, cleared by rst_i only)
//   undefined : no counter; beat_cnt_o is tied to 0
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        discard stage contents, suppress pop this cycle
//   fifo_empty_i   FIFO empty flag
//   fifo_data_i    FIFO head data
//   fifo_pop_o     pop strobe to the FIFO
//   valid_o/ready_i/data_o  output stream
//   occupancy_o    entries held in the stage (0..2)
//   beat_cnt_o     accepted output beats
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

    logic [1:0] state;
    logic       accept;

    assign valid_o     = (state != EMPTY);
    assign accept      = valid_o & ready_i;
    assign occupancy_o = state;
    assign fifo_pop_o  = !fifo_empty_i && (state != FULL) && !flush_i && !rst_i;

    fifo_stream_reader_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .load_i      (fifo_pop_o),
        .load_data_i (fifo_data_i),
        .accept_i    (accept),
        .state_o     (state),
        .data_o      (data_o)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    // Accepts in a flush cycle still count; flush does not clear the counter.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`else
    assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO and output stage modelled as queues.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, fifo_empty_i, ready_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_pop_o, valid_o;
    logic [DW-1:0] data_o;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] beat_cnt_o;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .occupancy_o  (occupancy_o),
        .beat_cnt_o   (beat_cnt_o)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q[$];   // words waiting in the FIFO
    logic [DW-1:0] stage_q[$];  // words held by the reader, head first
    logic [DW-1:0] shown;       // last word that was at the stream head
    int            cnt;         // expected beat counter
    int            delivered;
    logic [DW-1:0] seq;

`ifdef FIFO_STREAM_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom());
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic step(input logic rdy, input logic fl, input logic rs);
        logic exp_pop, acc;
        ready_i = rdy;
        flush_i = fl;
        rst_i   = rs;
        drive_fifo();
        @(negedge clk);
        exp_pop = (fifo_q.size() != 0) && (stage_q.size() < 2) && !fl && !rs;
        acc     = (stage_q.size() != 0) && rdy;
        check_eq("fifo_pop",  64'(fifo_pop_o),  64'(exp_pop));
        check_eq("valid",     64'(valid_o),     64'(stage_q.size() != 0));
        check_eq("data",      64'(data_o),      64'(shown));
        check_eq("occupancy", 64'(occupancy_o), 64'(stage_q.size()));
        check_eq("beat_cnt",  64'(beat_cnt_o),  64'(cnt));
        @(posedge clk);
        if (rs) begin
            stage_q.delete();
            cnt   = 0;
            shown = '0;
        end else begin
            if (acc) begin
                delivered++;
                if (STATS) cnt = (cnt + 1) % (1 << CW);
            end
            if (fl) begin
                stage_q.delete();
            end else begin
                if (acc) void'(stage_q.pop_front());
                if (exp_pop) stage_q.push_back(fifo_q.pop_front());
            end
            if (stage_q.size() != 0) shown = stage_q[0];
        end
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_data_i = '0;
        cnt = 0; shown = '0; delivered = 0; seq = 32'h1000;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Streaming A0..A7 with ready high
        for (int i = 0; i < 8; i++) push(DW'(32'hA0 + i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("stream_cnt", 64'(beat_cnt_o), STATS ? 64'd8 : 64'd0);

        // Backpressure: two pops then stall at FULL
        push(32'h11); push(32'h22); push(32'h33);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check_eq("bp_occ",  64'(occupancy_o), 64'd2);
        check_eq("bp_data", 64'(data_o),      64'h11);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);

        // Flush while FULL with the FIFO non-empty
        push(32'h55); push(32'h66); push(32'h77); push(32'h88);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("flush_valid", 64'(valid_o), 64'd0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("flush_head", 64'(data_o), 64'h77);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

        // Reset mid-operation while FULL
        push(32'hC1); push(32'hC2); push(32'hC3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("rst_data",  64'(data_o),     64'd0);
        check_eq("rst_cnt",   64'(beat_cnt_o), 64'd0);
        check_eq("rst_valid", 64'(valid_o),    64'd0);
        fifo_q.delete();
        step(1'b1, 1'b0, 1'b0);

        // Counter wrap: 17 beats on a 4-bit counter
        for (int i = 0; i < 17; i++) push(DW'(32'hD0 + i));
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("wrap_cnt", 64'(beat_cnt_o), STATS ? 64'd1 : 64'd0);

        // Random ready / refill / occasional flush and reset
        delivered = 0;
        for (int i = 0; i < 20000 && delivered < 1000; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) != 0) begin
                push(seq);
                seq = seq + 1;
            end
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 299) == 0));
        end
        check_eq("rand_delivered", 64'(delivered >= 1000), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
